// File: rtl/cms_pix28_dut_emulator_if.sv
// Pin-level bundle between the firmware IOB stage and the pix28 chip (or its emulator).
// master = firmware side driving the chip pins, slave = chip side driving the return pins.
interface cms_pix28_dut_emulator_if;
    logic config_clk;
    logic config_in;
    logic config_load;
    logic reset_not;
    logic bxclk;
    logic scan_in;
    logic scan_load;
    logic vin_test_trig_out;
    logic config_out;
    logic scan_out;
    logic dnn_output_0;
    logic dnn_output_1;
    logic dn_event_toggle;

    // No valid/ready: pins are free-running levels, sampled every fw_clk cycle by the receiver.
    modport master (
        output config_clk, config_in, config_load, reset_not,
        output bxclk, scan_in, scan_load, vin_test_trig_out,
        input  config_out, scan_out, dnn_output_0, dnn_output_1, dn_event_toggle
    );

    modport slave (
        input  config_clk, config_in, config_load, reset_not,
        input  bxclk, scan_in, scan_load, vin_test_trig_out,
        output config_out, scan_out, dnn_output_0, dnn_output_1, dn_event_toggle
    );
endinterface

// File: rtl/cms_pix28_dut_emulator.sv
// Emulates the pix28 chip pins for FPGA loopback: config chain, shadow latch, scan chain
// and BX-driven event generation, with all pin clocks oversampled as data on fw_clk.
module cms_pix28_dut_emulator #(
    parameter int CFG_WIDTH   = 64,
    parameter int SCAN_WIDTH  = 48,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 fw_clk,
    input  logic                 fw_rst_n,
    cms_pix28_dut_emulator_if.slave pins,
    output logic [CFG_WIDTH-1:0] cfg_shadow,
    output logic [7:0]           cfg_load_count
);

    localparam int NPIN = 8;

    logic [NPIN-1:0] pin_raw;
    logic [NPIN-1:0] sync_q [SYNC_STAGES];
    logic [NPIN-1:0] pin_s;

    assign pin_raw = {pins.vin_test_trig_out, pins.scan_load, pins.scan_in, pins.bxclk,
                      pins.reset_not, pins.config_load, pins.config_in, pins.config_clk};

    always_ff @(posedge fw_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pin_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign pin_s = sync_q[SYNC_STAGES-1];

    logic config_clk_s, config_in_s, config_load_s, reset_not_s;
    logic bxclk_s, scan_in_s, scan_load_s, trig_s;

    assign config_clk_s  = pin_s[0];
    assign config_in_s   = pin_s[1];
    assign config_load_s = pin_s[2];
    assign reset_not_s   = pin_s[3];
    assign bxclk_s       = pin_s[4];
    assign scan_in_s     = pin_s[5];
    assign scan_load_s   = pin_s[6];
    assign trig_s        = pin_s[7];

    // Edge detection on the clock-like pins, order {trig, bx, load, cfg}.
    logic [3:0] edge_now, edge_prev, edge_rise;
    logic       cfg_rise, load_rise, bx_rise, trig_rise;

    assign edge_now  = {trig_s, bxclk_s, config_load_s, config_clk_s};
    assign edge_rise = edge_now & ~edge_prev;
    assign cfg_rise  = edge_rise[0];
    assign load_rise = edge_rise[1];
    assign bx_rise   = edge_rise[2];
    assign trig_rise = edge_rise[3];

    always_ff @(posedge fw_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) edge_prev <= '0;
        else           edge_prev <= edge_now;
    end

    logic [CFG_WIDTH-1:0]  cfg_sr;
    logic [SCAN_WIDTH-1:0] scan_sr;
    logic [7:0]            bx_cnt;
    logic                  trig_pending;
    logic                  dnn_0_q, dnn_1_q, event_tog_q;
    logic                  bx_match, bx_event;

    assign bx_match = cfg_shadow[CFG_WIDTH-9] && (bx_cnt == cfg_shadow[CFG_WIDTH-1 -: 8]);
    assign bx_event = bx_rise && (trig_pending || bx_match);

    always_ff @(posedge fw_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            cfg_sr         <= '0;
            cfg_shadow     <= '0;
            cfg_load_count <= '0;
            scan_sr        <= '0;
            bx_cnt         <= '0;
            trig_pending   <= 1'b0;
            dnn_0_q        <= 1'b0;
            dnn_1_q        <= 1'b0;
            event_tog_q    <= 1'b0;
        end else if (!reset_not_s) begin
            cfg_sr         <= '0;
            cfg_shadow     <= '0;
            cfg_load_count <= '0;
            scan_sr        <= '0;
            bx_cnt         <= '0;
            trig_pending   <= 1'b0;
            dnn_0_q        <= 1'b0;
            dnn_1_q        <= 1'b0;
            event_tog_q    <= 1'b0;
        end else begin
            if (cfg_rise) cfg_sr <= {cfg_sr[CFG_WIDTH-2:0], config_in_s};
            // Shadow samples the pre-shift chain when load and shift coincide.
            if (load_rise) begin
                cfg_shadow <= cfg_sr;
                if (cfg_load_count != 8'hFF) cfg_load_count <= cfg_load_count + 8'd1;
            end
            if (bx_rise) begin
                if (scan_load_s) scan_sr <= cfg_shadow[SCAN_WIDTH-1:0];
                else             scan_sr <= {scan_sr[SCAN_WIDTH-2:0], scan_in_s};
                bx_cnt <= bx_cnt + 8'd1;
            end
            if (bx_event) begin
                event_tog_q <= ~event_tog_q;
                dnn_1_q     <= cfg_shadow[CFG_WIDTH-10];
                dnn_0_q     <= cfg_shadow[CFG_WIDTH-11];
            end
            // A trigger arriving on the firing BX is kept for the next one.
            if (trig_rise)     trig_pending <= 1'b1;
            else if (bx_event) trig_pending <= 1'b0;
        end
    end

    assign pins.config_out      = cfg_sr[CFG_WIDTH-1];
    assign pins.scan_out        = scan_sr[SCAN_WIDTH-1];
    assign pins.dnn_output_0    = dnn_0_q;
    assign pins.dnn_output_1    = dnn_1_q;
    assign pins.dn_event_toggle = event_tog_q;

endmodule

// File: tb/tb_cms_pix28_dut_emulator.sv
// Directed bench for the pix28 emulator: config loopback, load table, scan capture,
// BX match, trigger handling, chip reset and load-counter saturation.
module tb_cms_pix28_dut_emulator;

    localparam int PH = 4;

    logic        fw_clk = 1'b0;
    logic        fw_rst_n;
    logic [63:0] cfg_shadow;
    logic [7:0]  cfg_load_count;

    cms_pix28_dut_emulator_if pins ();

    cms_pix28_dut_emulator #(
        .CFG_WIDTH  (64),
        .SCAN_WIDTH (48),
        .SYNC_STAGES(2)
    ) dut (
        .fw_clk        (fw_clk),
        .fw_rst_n      (fw_rst_n),
        .pins          (pins),
        .cfg_shadow    (cfg_shadow),
        .cfg_load_count(cfg_load_count)
    );

    // clock / reset
    always #5 fw_clk = ~fw_clk;

    int pass_cnt  = 0;
    int check_cnt = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [63:0] word;
        logic [63:0] exp_shadow;
        logic [7:0]  exp_cnt;
        logic        exp_cfg_out;
    } load_vec_t;

    load_vec_t load_tab [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge fw_clk);
        #1;
    endtask

    // driver tasks
    task automatic shift_bit(input logic b);
        pins.config_in  = b;
        pins.config_clk = 1'b1;
        cycles(PH);
        pins.config_clk = 1'b0;
        cycles(PH);
    endtask

    task automatic load_pulse();
        pins.config_load = 1'b1;
        cycles(PH);
        pins.config_load = 1'b0;
        cycles(PH);
    endtask

    task automatic load_word(input logic [63:0] w);
        for (int i = 63; i >= 0; i--) shift_bit(w[i]);
        load_pulse();
    endtask

    task automatic bx_pulse(input logic sl, input logic with_trig);
        pins.scan_load = sl;
        pins.bxclk     = 1'b1;
        if (with_trig) pins.vin_test_trig_out = 1'b1;
        cycles(PH);
        pins.bxclk             = 1'b0;
        pins.vin_test_trig_out = 1'b0;
        cycles(PH);
        pins.scan_load = 1'b0;
    endtask

    task automatic trig_pulse();
        pins.vin_test_trig_out = 1'b1;
        cycles(PH);
        pins.vin_test_trig_out = 1'b0;
        cycles(PH);
    endtask

    task automatic chip_reset();
        pins.reset_not = 1'b0;
        cycles(4);
        pins.reset_not = 1'b1;
        cycles(4);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_shadow"}, cfg_shadow, 64'd0);
        check({tag, "_count"}, {56'd0, cfg_load_count}, 64'd0);
        check({tag, "_outs"}, {59'd0, pins.config_out, pins.scan_out, pins.dnn_output_1,
                               pins.dnn_output_0, pins.dn_event_toggle}, 64'd0);
    endtask

    initial begin
        logic [63:0] lb_word;
        logic [47:0] scan_word;
        logic        last_tog;
        int          flips;

        load_tab[0] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 8'd1, 1'b0};
        load_tab[1] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 8'd2, 1'b0};
        load_tab[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'd3, 1'b1};

        pins.config_clk = 0; pins.config_in = 0; pins.config_load = 0;
        pins.reset_not = 1; pins.bxclk = 0; pins.scan_in = 0; pins.scan_load = 0;
        pins.vin_test_trig_out = 0;
        fw_rst_n = 1'b0;
        cycles(3);
        check_outputs_zero("por");
        fw_rst_n = 1'b1;
        cycles(4);

        // table of loads: shadow, counter and echo of the chain MSB
        for (int v = 0; v < 3; v++) begin
            load_word(load_tab[v].word);
            check($sformatf("tab%0d_shadow", v), cfg_shadow, load_tab[v].exp_shadow);
            check($sformatf("tab%0d_count", v), {56'd0, cfg_load_count}, {56'd0, load_tab[v].exp_cnt});
            check($sformatf("tab%0d_cfg_out", v), {63'd0, pins.config_out}, {63'd0, load_tab[v].exp_cfg_out});
        end

        // mid-stream asynchronous reset with config_clk toggling
        pins.config_in  = 1'b1;
        pins.config_clk = 1'b1;
        cycles(2);
        fw_rst_n = 1'b0;
        #1;
        check_outputs_zero("arst_async");
        pins.config_clk = 1'b0; cycles(4);
        pins.config_clk = 1'b1; cycles(4);
        pins.config_clk = 1'b0; cycles(2);
        fw_rst_n = 1'b1;
        cycles(10);
        check_outputs_zero("arst_release");

        // config loopback
        lb_word = 64'hDEAD_BEEF_0123_4567;
        load_word(lb_word);
        check("lb_shadow", cfg_shadow, 64'hDEAD_BEEF_0123_4567);
        check("lb_count", {56'd0, cfg_load_count}, 64'd1);
        for (int i = 63; i >= 0; i--) exp_q.push_back({63'd0, lb_word[i]});
        for (int i = 0; i < 64; i++) begin
            check($sformatf("lb_bit%0d", i), {63'd0, pins.config_out}, exp_q.pop_front());
            shift_bit(1'b0);
        end
        check("lb_drained", {63'd0, pins.config_out}, 64'd0);

        // scan capture and serialization
        scan_word = 48'hA5A5_0F0F_3C3C;
        load_word({16'h0000, scan_word});
        check("scan_count", {56'd0, cfg_load_count}, 64'd2);
        for (int i = 47; i >= 0; i--) exp_q.push_back({63'd0, scan_word[i]});
        bx_pulse(1'b1, 1'b0);
        for (int i = 0; i < 48; i++) begin
            check($sformatf("scan_bit%0d", i), {63'd0, pins.scan_out}, exp_q.pop_front());
            if (i < 47) bx_pulse(1'b0, 1'b0);
        end

        // BX match at bx_cnt 5, then again after wrap
        chip_reset();
        check_outputs_zero("creset1");
        load_word(64'h05C0_0000_0000_0000);
        for (int p = 1; p <= 5; p++) bx_pulse(1'b0, 1'b0);
        check("match_before", {63'd0, pins.dn_event_toggle}, 64'd0);
        bx_pulse(1'b0, 1'b0);
        check("match_fire", {61'd0, pins.dn_event_toggle, pins.dnn_output_1, pins.dnn_output_0}, 64'b110);
        flips    = 0;
        last_tog = pins.dn_event_toggle;
        for (int p = 7; p <= 261; p++) begin
            bx_pulse(1'b0, 1'b0);
            if (pins.dn_event_toggle !== last_tog) flips++;
            last_tog = pins.dn_event_toggle;
        end
        check("match_quiet_flips", 64'(flips), 64'd0);
        bx_pulse(1'b0, 1'b0);
        check("match_wrap", {63'd0, pins.dn_event_toggle}, 64'd0);

        // test trigger, match disabled, dnn pattern 01
        load_word(64'h0020_0000_0000_0000);
        trig_pulse();
        check("trig_no_bx", {63'd0, pins.dn_event_toggle}, 64'd0);
        bx_pulse(1'b0, 1'b0);
        check("trig_fire", {61'd0, pins.dn_event_toggle, pins.dnn_output_1, pins.dnn_output_0}, 64'b101);
        bx_pulse(1'b0, 1'b0);
        check("trig_once", {63'd0, pins.dn_event_toggle}, 64'd1);
        trig_pulse();
        bx_pulse(1'b0, 1'b1);
        check("trig_coinc_fire", {63'd0, pins.dn_event_toggle}, 64'd0);
        bx_pulse(1'b0, 1'b0);
        check("trig_coinc_held", {63'd0, pins.dn_event_toggle}, 64'd1);
        bx_pulse(1'b0, 1'b0);
        check("trig_coinc_done", {63'd0, pins.dn_event_toggle}, 64'd1);

        // load counter saturation, then chip reset with config_clk toggling
        for (int i = 0; i < 300; i++) load_pulse();
        check("sat_count", {56'd0, cfg_load_count}, 64'd255);
        pins.config_in  = 1'b1;
        pins.reset_not  = 1'b0;
        pins.config_clk = 1'b1;
        cycles(4);
        pins.config_clk = 1'b0;
        pins.reset_not  = 1'b1;
        cycles(PH);
        check_outputs_zero("creset2");
        load_pulse();
        check("creset2_noshift", cfg_shadow, 64'd0);
        check("creset2_count", {56'd0, cfg_load_count}, 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
